// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes for the writeback port controller.
// Holds the writeback request struct and a one-hot helper for hazard masks.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_AW-1:0] a);
    onehot_reg    = '0;
    onehot_reg[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write port and hazard bus of regfile_wb_arbiter.
// Forwarding read-port signals exist only when RF_WB_FWD_EN is defined.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                wb_hold;
  logic                req0_valid;
  logic                req1_valid;
  logic [REG_AW-1:0]   req0_addr;
  logic [REG_AW-1:0]   req1_addr;
  logic [XLEN-1:0]     req0_data;
  logic [XLEN-1:0]     req1_data;
  logic                req0_ready;
  logic                req1_ready;
  logic [REG_AW-1:0]   A3;
  logic [XLEN-1:0]     WD3;
  logic                WE3;
  logic [NUM_REGS-1:0] pending_mask;
`ifdef RF_WB_FWD_EN
  logic [REG_AW-1:0]   rd_addr1;
  logic [REG_AW-1:0]   rd_addr2;
  logic [XLEN-1:0]     rd_data1;
  logic [XLEN-1:0]     rd_data2;
  logic [XLEN-1:0]     fwd_data1;
  logic [XLEN-1:0]     fwd_data2;
`endif

  modport master (
    output wb_hold, req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
`ifdef RF_WB_FWD_EN
    output rd_addr1, rd_addr2, rd_data1, rd_data2,
    input  fwd_data1, fwd_data2,
`endif
    input  req0_ready, req1_ready, A3, WD3, WE3, pending_mask
  );

  modport slave (
    input  wb_hold, req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
`ifdef RF_WB_FWD_EN
    input  rd_addr1, rd_addr2, rd_data1, rd_data2,
    output fwd_data1, fwd_data2,
`endif
    output req0_ready, req1_ready, A3, WD3, WE3, pending_mask
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational; zero grant while hold is high.
// last_grant is the index of the requester served most recently; the other one wins ties.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (!hold) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port controller: round-robin over two writeback requesters into a one-entry stage, 1-cycle latency.
// Stage drains every cycle so ready = grant; wb_hold/rst block grants. Optional bypass mux under RF_WB_FWD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  regfile_wb_arbiter_if.slave bus
);

  logic [1:0] grant;
  logic       last_grant;
  logic       stg_v;
  wb_req_t    stg;
  wb_req_t    req0;
  wb_req_t    req1;
  logic       we;

  assign req0 = {bus.req0_addr, bus.req0_data};
  assign req1 = {bus.req1_addr, bus.req1_data};

  // Holding the arbiter during reset keeps both readies low while rst is asserted.
  rr_arbiter2 u_arb (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .hold       (bus.wb_hold | rst),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_v      <= 1'b0;
      stg        <= '0;
      last_grant <= 1'b1;
    end else if (grant[0]) begin
      stg_v      <= 1'b1;
      stg        <= req0;
      last_grant <= 1'b0;
    end else if (grant[1]) begin
      stg_v      <= 1'b1;
      stg        <= req1;
      last_grant <= 1'b1;
    end else begin
      stg_v      <= 1'b0;
      stg        <= '0;
    end
  end

  // x0 writes occupy the slot but never reach the file or the hazard mask.
  assign we               = stg_v & (stg.addr != '0);
  assign bus.A3           = stg.addr;
  assign bus.WD3          = stg.data;
  assign bus.WE3          = we;
  assign bus.pending_mask = we ? onehot_reg(stg.addr) : '0;

`ifdef RF_WB_FWD_EN
  assign bus.fwd_data1 = (we && stg.addr == bus.rd_addr1) ? stg.data : bus.rd_data1;
  assign bus.fwd_data2 = (we && stg.addr == bus.rd_addr2) ? stg.data : bus.rd_data2;
`endif

endmodule
